atm_pin_verifier: RTL and testbench

//  Upstream stage of the ATM transaction FSM: collects keypad digits after card insertion,

---
 rtl/atm_pkg.sv | 46 ++++
 rtl/atm_pin_shift_reg.sv | 43 ++++
 rtl/atm_pin_verifier.sv | 171 +++++++++++++++++
 tb/tb_atm_pin_verifier.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// ---------------------------------------------------------------------------
// atm_pkg -- shared constants and encodings for the ATM datapath.
//
// Contents:
//   DIGIT_W, PIN_DIGITS   keypad digit width and digits per PIN
//   BCD_MAX               largest legal keypad digit (9)
//   PV_*                  PIN verifier state encodings (3-bit)
//   txn_state_e           transaction FSM state encoding
//   amount_t              transaction amount type
//   is_bcd()              helper: digit is a legal BCD value
// ---------------------------------------------------------------------------
package atm_pkg;

  localparam int DIGIT_W    = 4;
  localparam int PIN_DIGITS = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // PIN verifier states
  localparam int         PV_STATE_W = 3;
  localparam logic [2:0] PV_IDLE    = 3'd0;
  localparam logic [2:0] PV_ENTRY   = 3'd1;
  localparam logic [2:0] PV_CHECK   = 3'd2;
  localparam logic [2:0] PV_GRANTED = 3'd3;
  localparam logic [2:0] PV_LOCKED  = 3'd4;

  // Downstream transaction FSM encodings; it waits in TXN_CARD_INSERTED
  // until the verifier raises PIN.
  typedef enum logic [2:0] {
    TXN_IDLE          = 3'd0,
    TXN_CARD_INSERTED = 3'd1,
    TXN_MENU          = 3'd2,
    TXN_WITHDRAW      = 3'd3,
    TXN_DEPOSIT       = 3'd4,
    TXN_BALANCE       = 3'd5,
    TXN_EJECT         = 3'd6
  } txn_state_e;

  localparam int AMOUNT_W = 16;
  typedef logic [AMOUNT_W-1:0] amount_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/atm_pin_shift_reg.sv
// ---------------------------------------------------------------------------
// atm_pin_shift_reg -- keypad digit buffer with saturating digit count.
//
// Ports:
//   clock   in   system clock
//   reset   in   synchronous, active-high
//   clear   in   empty the buffer and zero the count (wins over shift)
//   shift   in   shift digit in at the least-significant position
//   digit   in   digit to shift in
//   buffer  out  collected digits; first digit typed ends up most significant
//   count   out  digits held, saturates at N
//   full    out  count == N; further shifts are ignored
// ---------------------------------------------------------------------------
module atm_pin_shift_reg
  import atm_pkg::*;
#(
  parameter  int N     = PIN_DIGITS,
  parameter  int W     = DIGIT_W,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic [W-1:0]     digit,
  output logic [N*W-1:0]   buffer,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  assign full = (count == CNT_W'(N));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      buffer <= '0;
      count  <= '0;
    end else if (shift && !full) begin
      buffer <= {buffer[N*W-W-1:0], digit};
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/atm_pin_verifier.sv
// ---------------------------------------------------------------------------
// atm_pin_verifier -- collects keypad digits after card insertion, checks
// them against the card's stored PIN and raises the PIN-accepted level.
// Counts wrong attempts, locks out (retaining the card) after MAX_TRIES
// failures, and clears a half-typed entry after TIMEOUT_CYCLES idle cycles.
//
// Keypad protocol: key_valid, key_enter and key_clear are single-cycle
// strobes with no back-pressure; each strobe is consumed in the cycle it is
// high. They act only in ENTRY with the card present, priority
// clear > enter > digit.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-high
//   card         in   card present level
//   ref_pin      in   stored PIN, MS digit = first digit typed
//   key_valid    in   digit strobe, key_digit valid
//   key_digit    in   BCD digit 0..9 (larger values ignored)
//   key_enter    in   submit strobe
//   key_clear    in   discard-entry strobe
//   PIN          out  level: PIN accepted
//   pin_fail     out  one-cycle pulse per rejected attempt
//   tries_left   out  remaining attempts
//   locked       out  level: lockout active
//   retain_card  out  one-cycle pulse on entering LOCKED
//   fsm_state    out  current state (PV_* encoding) for observation
// ---------------------------------------------------------------------------
module atm_pin_verifier
  import atm_pkg::*;
#(
  parameter  int PIN_N          = PIN_DIGITS,
  parameter  int DW             = DIGIT_W,
  parameter  int MAX_TRIES      = 3,
  parameter  int TIMEOUT_CYCLES = 1000,
  localparam int TRY_W          = $clog2(MAX_TRIES + 1),
  localparam int TIMER_W        = $clog2(TIMEOUT_CYCLES),
  localparam int CNT_W          = $clog2(PIN_N + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  card,
  input  logic [PIN_N*DW-1:0]   ref_pin,
  input  logic                  key_valid,
  input  logic [DW-1:0]         key_digit,
  input  logic                  key_enter,
  input  logic                  key_clear,
  output logic                  PIN,
  output logic                  pin_fail,
  output logic [TRY_W-1:0]      tries_left,
  output logic                  locked,
  output logic                  retain_card,
  output logic [PV_STATE_W-1:0] fsm_state
);

  logic [PV_STATE_W-1:0] state;
  logic [PV_STATE_W-1:0] state_next;
  logic [TIMER_W-1:0]    timer;

  logic [PIN_N*DW-1:0]   buffer;
  logic [CNT_W-1:0]      count;
  logic                  full;

  logic                  in_entry;
  logic                  any_strobe;
  logic                  timeout;
  logic                  short_enter;
  logic                  full_enter;
  logic                  check_bad;
  logic                  check_good;
  logic                  attempt_fail;
  logic [TRY_W-1:0]      tries_dec;
  logic                  buf_clear;
  logic                  buf_shift;

  atm_pin_shift_reg #(
    .N (PIN_N),
    .W (DW)
  ) u_shift_reg (
    .clock  (clock),
    .reset  (reset),
    .clear  (buf_clear),
    .shift  (buf_shift),
    .digit  (key_digit),
    .buffer (buffer),
    .count  (count),
    .full   (full)
  );

  assign in_entry   = (state == PV_ENTRY);
  assign any_strobe = key_valid | key_enter | key_clear;

  // Idle timeout only fires on a cycle without any strobe; a strobe always
  // restarts the idle window instead.
  assign timeout = in_entry && card && !any_strobe &&
                   (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  // Card removal outranks every key; key_clear outranks key_enter.
  assign short_enter = in_entry && card && !key_clear && key_enter && !full;
  assign full_enter  = in_entry && card && !key_clear && key_enter && full;

  // ref_pin is looked at only here, in the single CHECK cycle.
  assign check_bad  = (state == PV_CHECK) && card && (buffer != ref_pin);
  assign check_good = (state == PV_CHECK) && card && (buffer == ref_pin);

  assign attempt_fail = short_enter || check_bad;
  assign tries_dec    = (tries_left != '0) ? tries_left - 1'b1 : '0;

  // pin_fail is raised in the deciding cycle; retain_card follows one cycle
  // later in the first LOCKED cycle, so the two never overlap.
  assign pin_fail = attempt_fail;

  // Buffer only holds data while in ENTRY (and through CHECK, which reads it
  // before the clear takes effect at the clock edge).
  assign buf_clear = !in_entry || !card || key_clear || short_enter || timeout;
  assign buf_shift = in_entry && card && !key_clear && !key_enter &&
                     key_valid && is_bcd(key_digit) && (count < CNT_W'(PIN_N));

  assign PIN       = (state == PV_GRANTED);
  assign locked    = (state == PV_LOCKED);
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    case (state)
      PV_IDLE: begin
        if (card) state_next = PV_ENTRY;
      end
      PV_ENTRY: begin
        if (!card)                 state_next = PV_IDLE;
        else if (full_enter)       state_next = PV_CHECK;
        else if (short_enter)      state_next = (tries_dec == '0) ? PV_LOCKED : PV_ENTRY;
      end
      PV_CHECK: begin
        if (!card)                 state_next = PV_IDLE;
        else if (check_good)       state_next = PV_GRANTED;
        else                       state_next = (tries_dec == '0) ? PV_LOCKED : PV_ENTRY;
      end
      PV_GRANTED: begin
        if (!card) state_next = PV_IDLE;
      end
      PV_LOCKED: begin
        state_next = PV_LOCKED;
      end
      default: state_next = PV_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= PV_IDLE;
      tries_left  <= TRY_W'(MAX_TRIES);
      timer       <= '0;
      retain_card <= 1'b0;
    end else begin
      state       <= state_next;
      retain_card <= attempt_fail && (tries_dec == '0);

      // A fresh insertion always starts with the full allowance.
      if (state == PV_IDLE && card)
        tries_left <= TRY_W'(MAX_TRIES);
      else if (attempt_fail)
        tries_left <= tries_dec;

      if (!in_entry || any_strobe || timeout)
        timer <= '0;
      else
        timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_atm_pin_verifier.sv
module tb_atm_pin_verifier;
  import atm_pkg::*;

  localparam int TIMEOUT = 1000;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        card = 1'b0;
  logic [15:0] ref_pin = 16'h1234;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        key_enter = 1'b0;
  logic        key_clear = 1'b0;
  logic        PIN;
  logic        pin_fail;
  logic [1:0]  tries_left;
  logic        locked;
  logic        retain_card;
  logic [2:0]  fsm_state;

  int vectors = 0;
  int miscompares = 0;

  // pulse counters, sampled mid-cycle
  int fail_cnt = 0;
  int retain_cnt = 0;
  int both_cnt = 0;

  atm_pin_verifier #(
    .MAX_TRIES      (3),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .card        (card),
    .ref_pin     (ref_pin),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .key_enter   (key_enter),
    .key_clear   (key_clear),
    .PIN         (PIN),
    .pin_fail    (pin_fail),
    .tries_left  (tries_left),
    .locked      (locked),
    .retain_card (retain_card),
    .fsm_state   (fsm_state)
  );

  always @(negedge clock) begin
    if (!reset) begin
      if (pin_fail) fail_cnt++;
      if (retain_card) retain_cnt++;
      if (pin_fail && retain_card) both_cnt++;
    end
  end

  // driver tasks: inputs change 2 time units after posedge
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter_key();
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
  endtask

  task automatic press_pin(input logic [15:0] p);
    logic [15:0] v;
    v = p;
    for (int i = 3; i >= 0; i--) press(v[i*4 +: 4]);
  endtask

  task automatic apply_reset();
    card = 1'b0; key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic insert_card();
    card = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (PIN !== 1'b0) begin miscompares++; $display("FAIL reset_pin: got %0b expected 0", PIN); end
    vectors++; if (pin_fail !== 1'b0) begin miscompares++; $display("FAIL reset_pin_fail: got %0b expected 0", pin_fail); end
    vectors++; if (tries_left !== 2'd3) begin miscompares++; $display("FAIL reset_tries: got %0d expected 3", tries_left); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    vectors++; if (retain_card !== 1'b0) begin miscompares++; $display("FAIL reset_retain: got %0b expected 0", retain_card); end
    vectors++; if (fsm_state !== PV_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, PV_IDLE); end
  endtask

  task automatic test_correct_pin();
    int f0;
    apply_reset();
    f0 = fail_cnt;
    ref_pin = 16'h1234;
    insert_card();
    vectors++; if (fsm_state !== PV_ENTRY) begin miscompares++; $display("FAIL ok_entry_state: got %0d expected %0d", fsm_state, PV_ENTRY); end
    press_pin(16'h1234);
    enter_key();
    vectors++; if (PIN !== 1'b0) begin miscompares++; $display("FAIL ok_pin_n1: got %0b expected 0", PIN); end
    tick();
    vectors++; if (PIN !== 1'b1) begin miscompares++; $display("FAIL ok_pin_n2: got %0b expected 1", PIN); end
    vectors++; if (tries_left !== 2'd3) begin miscompares++; $display("FAIL ok_tries: got %0d expected 3", tries_left); end
    tick();
    vectors++; if (PIN !== 1'b1) begin miscompares++; $display("FAIL ok_pin_hold: got %0b expected 1", PIN); end
    vectors++; if (fail_cnt - f0 !== 0) begin miscompares++; $display("FAIL ok_no_fail: got %0d pulses expected 0", fail_cnt - f0); end
    card = 1'b0;
    tick();
    vectors++; if (PIN !== 1'b0) begin miscompares++; $display("FAIL ok_pin_drop: got %0b expected 0", PIN); end
    vectors++; if (fsm_state !== PV_IDLE) begin miscompares++; $display("FAIL ok_idle: got %0d expected %0d", fsm_state, PV_IDLE); end
  endtask

  task automatic test_lockout();
    int f0, r0;
    apply_reset();
    f0 = fail_cnt; r0 = retain_cnt;
    insert_card();
    for (int i = 0; i < 3; i++) begin
      press_pin(16'h1235);
      enter_key();
      vectors++; if (pin_fail !== 1'b1) begin miscompares++; $display("FAIL lock_fail_%0d: got %0b expected 1", i, pin_fail); end
      tick();
      vectors++; if (tries_left !== 2'(2 - i)) begin miscompares++; $display("FAIL lock_tries_%0d: got %0d expected %0d", i, tries_left, 2 - i); end
      if (i < 2) begin
        vectors++; if (fsm_state !== PV_ENTRY) begin miscompares++; $display("FAIL lock_reentry_%0d: got %0d expected %0d", i, fsm_state, PV_ENTRY); end
      end
    end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL lock_locked: got %0b expected 1", locked); end
    vectors++; if (retain_card !== 1'b1) begin miscompares++; $display("FAIL lock_retain: got %0b expected 1", retain_card); end
    tick();
    vectors++; if (retain_card !== 1'b0) begin miscompares++; $display("FAIL lock_retain_once: got %0b expected 0", retain_card); end
    press_pin(16'h1234);
    enter_key();
    tick(); tick();
    vectors++; if (PIN !== 1'b0) begin miscompares++; $display("FAIL lock_ignore_pin: got %0b expected 0", PIN); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL lock_held: got %0b expected 1", locked); end
    vectors++; if (tries_left !== 2'd0) begin miscompares++; $display("FAIL lock_tries0: got %0d expected 0", tries_left); end
    vectors++; if (fail_cnt - f0 !== 3) begin miscompares++; $display("FAIL lock_fail_count: got %0d expected 3", fail_cnt - f0); end
    vectors++; if (retain_cnt - r0 !== 1) begin miscompares++; $display("FAIL lock_retain_count: got %0d expected 1", retain_cnt - r0); end
  endtask

  task automatic test_short_and_extra();
    apply_reset();
    insert_card();
    press(4'd1); press(4'd2);
    key_enter = 1'b1;
    #1;
    vectors++; if (pin_fail !== 1'b1) begin miscompares++; $display("FAIL short_fail: got %0b expected 1", pin_fail); end
    tick();
    key_enter = 1'b0;
    vectors++; if (tries_left !== 2'd2) begin miscompares++; $display("FAIL short_tries: got %0d expected 2", tries_left); end
    press(4'd1); press(4'd2); press(4'hA); press(4'd3); press(4'd4); press(4'd9);
    enter_key();
    tick();
    vectors++; if (PIN !== 1'b1) begin miscompares++; $display("FAIL extra_pin: got %0b expected 1", PIN); end
    vectors++; if (tries_left !== 2'd2) begin miscompares++; $display("FAIL extra_tries: got %0d expected 2", tries_left); end
  endtask

  task automatic test_priority();
    apply_reset();
    insert_card();
    press(4'd1); press(4'd2); press(4'd3);
    // clear, enter and a digit all in one cycle: clear wins
    key_clear = 1'b1; key_enter = 1'b1; key_valid = 1'b1; key_digit = 4'd7;
    #1;
    vectors++; if (pin_fail !== 1'b0) begin miscompares++; $display("FAIL prio_clear_nofail: got %0b expected 0", pin_fail); end
    tick();
    key_clear = 1'b0; key_enter = 1'b0; key_valid = 1'b0;
    press_pin(16'h1234);
    // enter together with a digit: enter wins
    key_enter = 1'b1; key_valid = 1'b1; key_digit = 4'd9;
    tick();
    key_enter = 1'b0; key_valid = 1'b0;
    tick();
    vectors++; if (PIN !== 1'b1) begin miscompares++; $display("FAIL prio_pin: got %0b expected 1", PIN); end
    vectors++; if (tries_left !== 2'd3) begin miscompares++; $display("FAIL prio_tries: got %0d expected 3", tries_left); end
  endtask

  task automatic test_timeout();
    apply_reset();
    insert_card();
    press(4'd1); press(4'd2);
    repeat (TIMEOUT) tick();
    press(4'd3); press(4'd4);
    key_enter = 1'b1;
    #1;
    vectors++; if (pin_fail !== 1'b1) begin miscompares++; $display("FAIL tmo_short_fail: got %0b expected 1", pin_fail); end
    tick();
    key_enter = 1'b0;
    vectors++; if (tries_left !== 2'd2) begin miscompares++; $display("FAIL tmo_tries: got %0d expected 2", tries_left); end
    // just under the timeout: entry survives
    press(4'd1); press(4'd2); press(4'd3);
    repeat (TIMEOUT - 2) tick();
    press(4'd4);
    enter_key();
    tick();
    vectors++; if (PIN !== 1'b1) begin miscompares++; $display("FAIL tmo_edge_pin: got %0b expected 1", PIN); end
  endtask

  task automatic test_card_removal_and_reset();
    apply_reset();
    insert_card();
    enter_key();
    vectors++; if (tries_left !== 2'd2) begin miscompares++; $display("FAIL rm_tries2: got %0d expected 2", tries_left); end
    press_pin(16'h1235);
    enter_key();
    card = 1'b0;
    #1;
    vectors++; if (pin_fail !== 1'b0) begin miscompares++; $display("FAIL rm_nofail: got %0b expected 0", pin_fail); end
    tick();
    vectors++; if (fsm_state !== PV_IDLE) begin miscompares++; $display("FAIL rm_idle: got %0d expected %0d", fsm_state, PV_IDLE); end
    vectors++; if (tries_left !== 2'd2) begin miscompares++; $display("FAIL rm_keep_tries: got %0d expected 2", tries_left); end
    insert_card();
    vectors++; if (tries_left !== 2'd3) begin miscompares++; $display("FAIL rm_reload: got %0d expected 3", tries_left); end
    repeat (3) enter_key();
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL rm_locked: got %0b expected 1", locked); end
    card = 1'b0;
    tick();
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL rm_lock_card_ignored: got %0b expected 1", locked); end
    apply_reset();
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rm_reset_unlock: got %0b expected 0", locked); end
    vectors++; if (fsm_state !== PV_IDLE) begin miscompares++; $display("FAIL rm_reset_idle: got %0d expected %0d", fsm_state, PV_IDLE); end
    vectors++; if (tries_left !== 2'd3) begin miscompares++; $display("FAIL rm_reset_tries: got %0d expected 3", tries_left); end
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL fail_retain_overlap: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_correct_pin();
    test_lockout();
    test_short_and_extra();
    test_priority();
    test_timeout();
    test_card_removal_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
